// File: rtl/req_enc16_4_if.sv
// ---------------------------------------------------------------------------
// req_enc16_4_if
//   Bundles the request/handshake/status signals of the 16-to-4 request
//   encoder so the producer and the encoder share one port.
//
//   Signals
//     en       block enable (0 = no capture, no service)
//     req      N request bits, sampled every clock edge while en=1
//     ack      consumer accepts the presented code (valid & ack = transfer)
//     code     index of the priority pending bit, 0 when valid=0
//     valid    en & |pend
//     pend     pending register
//     count    population count of pend
//     dropped  one-cycle pulse: a request hit an already-pending bit
//
//   Modports
//     master   drives en/req/ack, observes the encoder outputs
//     slave    the encoder side
// ---------------------------------------------------------------------------
interface req_enc16_4_if #(
    parameter int N = 16
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          en;
    logic [N-1:0]  req;
    logic          ack;
    logic [W-1:0]  code;
    logic          valid;
    logic [N-1:0]  pend;
    logic [CW-1:0] count;
    logic          dropped;

    modport master (
        output en, req, ack,
        input  code, valid, pend, count, dropped
    );

    modport slave (
        input  en, req, ack,
        output code, valid, pend, count, dropped
    );
endinterface

// File: rtl/req_enc16_4.sv
// ---------------------------------------------------------------------------
// req_enc16_4
//   Sequential 16-to-4 request encoder (reverse path of dec4_16).
//   Request bits are accumulated into a pending register; the priority
//   pending index is presented as a binary code with a valid/ack handshake
//   and one index is retired per accepted transfer.
//
//   Ports
//     clk      system clock, rising edge
//     reset    asynchronous, active-high; clears pend and dropped
//     bus      req_enc16_4_if.slave: en, req, ack in; code, valid, pend,
//              count, dropped out
//
//   Parameters
//     N          number of request lines (16)
//     HIGH_FIRST 1: highest set index has priority, 0: lowest set index
// ---------------------------------------------------------------------------
module req_enc16_4 #(
    parameter int N          = 16,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    req_enc16_4_if.slave bus
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  pend_q;
    logic          dropped_q;

    logic [W-1:0]  sel_idx;
    logic [CW-1:0] pop_cnt;
    logic          valid_c;
    logic          xfer;
    logic [N-1:0]  clr;
    logic [N-1:0]  cap;

    // Priority select. The loop runs towards the winning end so the last
    // match seen is the one that sticks.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it holding its old value and infer a latch.
    always_comb begin
        sel_idx = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend_q[i]) sel_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend_q[i]) sel_idx = W'(i);
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            pop_cnt = pop_cnt + CW'(pend_q[i]);
        end
    end

    assign valid_c = bus.en & (|pend_q);
    assign xfer    = valid_c & bus.ack;
    assign cap     = bus.en ? bus.req : '0;

    // One-hot clear of the presented index, only on an accepted transfer.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = xfer && (sel_idx == W'(i));
        end
    end

    // A re-request of the bit being cleared this edge wins and is not a drop.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    // NOTE: all state is cleared by the asynchronous reset; there is no memory
    // array here that would need to be left out of the reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            pend_q    <= (pend_q & ~clr) | cap;
            dropped_q <= |(cap & pend_q & ~clr);
        end
    end

    assign bus.code    = valid_c ? sel_idx : '0;
    assign bus.valid   = valid_c;
    assign bus.pend    = pend_q;
    assign bus.count   = pop_cnt;
    assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_req_enc16_4.sv
// ---------------------------------------------------------------------------
// tb_req_enc16_4
//   Two encoders (HIGH_FIRST=1 and HIGH_FIRST=0) driven with identical
//   stimulus. Expected transfer codes are queued when ack is issued; a
//   monitor on the falling edge pops and compares on every valid & ack.
//   Status outputs are compared directly in the stimulus process.
// ---------------------------------------------------------------------------
module tb_req_enc16_4;
    logic clk;
    logic reset;

    req_enc16_4_if #(.N(16)) if_hi ();
    req_enc16_4_if #(.N(16)) if_lo ();

    req_enc16_4 #(.N(16), .HIGH_FIRST(1'b1)) dut_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (if_hi.slave)
    );

    req_enc16_4 #(.N(16), .HIGH_FIRST(1'b0)) dut_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (if_lo.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] q_hi[$];
    logic [3:0] q_lo[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [15:0] req, input logic ack);
        if_hi.en  = en;  if_hi.req = req;  if_hi.ack = ack;
        if_lo.en  = en;  if_lo.req = req;  if_lo.ack = ack;
    endtask

    task automatic push_both(input logic [3:0] c_hi, input logic [3:0] c_lo);
        q_hi.push_back(c_hi);
        q_lo.push_back(c_lo);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick(input logic [15:0] p, input bit high_first);
        if (high_first) begin
            for (int i = 15; i >= 0; i--) if (p[i]) return 4'(i);
        end else begin
            for (int i = 0; i < 16; i++) if (p[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Scoreboard monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (if_hi.valid && if_hi.ack) begin
            n_vec++;
            if (q_hi.size() == 0) begin
                n_err++;
                $display("FAIL xfer_hi: unexpected transfer code %0d at %0t", if_hi.code, $time);
            end else begin
                logic [3:0] e;
                e = q_hi.pop_front();
                if (if_hi.code !== e) begin
                    n_err++;
                    $display("FAIL xfer_hi: got code %0d, expected %0d at %0t", if_hi.code, e, $time);
                end
            end
        end
        if (if_lo.valid && if_lo.ack) begin
            n_vec++;
            if (q_lo.size() == 0) begin
                n_err++;
                $display("FAIL xfer_lo: unexpected transfer code %0d at %0t", if_lo.code, $time);
            end else begin
                logic [3:0] e;
                e = q_lo.pop_front();
                if (if_lo.code !== e) begin
                    n_err++;
                    $display("FAIL xfer_lo: got code %0d, expected %0d at %0t", if_lo.code, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ph, pl, clr_h, clr_l, cap, nh, nl;
        logic        dh, dl, r_en, r_ack;
        logic [15:0] r_req;
        logic [3:0]  c;

        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(if_hi.valid), 32'd0);
        check("rst_code", 32'(if_hi.code), 32'd0);
        check("rst_count", 32'(if_hi.count), 32'd0);
        check("rst_pend", 32'(if_hi.pend), 32'd0);
        check("rst_dropped", 32'(if_hi.dropped), 32'd0);

        // 1: single request, single ack
        drive(1'b1, 16'h0001, 1'b0);
        cycle();
        check("t1_valid", 32'(if_hi.valid), 32'd1);
        check("t1_code", 32'(if_hi.code), 32'd0);
        check("t1_count", 32'(if_hi.count), 32'd1);
        drive(1'b1, 16'h0000, 1'b1);
        push_both(4'd0, 4'd0);
        cycle();
        check("t1_valid_after", 32'(if_hi.valid), 32'd0);
        check("t1_pend_after", 32'(if_hi.pend), 32'd0);
        drive(1'b1, 16'h0000, 1'b0);

        // 2: 16'h8421 with ack held: back-to-back transfers in priority order
        drive(1'b1, 16'h8421, 1'b1);
        push_both(4'd15, 4'd0);
        push_both(4'd10, 4'd5);
        push_both(4'd5, 4'd10);
        push_both(4'd0, 4'd15);
        cycle();
        check("t2_code_hi", 32'(if_hi.code), 32'd15);
        check("t2_code_lo", 32'(if_lo.code), 32'd0);
        check("t2_count", 32'(if_hi.count), 32'd4);
        drive(1'b1, 16'h0000, 1'b1);
        repeat (4) cycle();
        check("t2_valid_hi", 32'(if_hi.valid), 32'd0);
        check("t2_valid_lo", 32'(if_lo.valid), 32'd0);
        drive(1'b1, 16'h0000, 1'b0);

        // 3: drop on already-pending bit; no drop when cleared the same edge
        drive(1'b1, 16'h0400, 1'b0);
        cycle();
        check("t3_dropped_idle", 32'(if_hi.dropped), 32'd0);
        cycle();
        check("t3_dropped", 32'(if_hi.dropped), 32'd1);
        check("t3_dropped_lo", 32'(if_lo.dropped), 32'd1);
        check("t3_count", 32'(if_hi.count), 32'd1);
        drive(1'b1, 16'h0000, 1'b0);
        cycle();
        check("t3_dropped_pulse", 32'(if_hi.dropped), 32'd0);
        drive(1'b1, 16'h0400, 1'b1);
        push_both(4'd10, 4'd10);
        cycle();
        check("t3_rereq_dropped", 32'(if_hi.dropped), 32'd0);
        check("t3_rereq_pend", 32'(if_hi.pend), 32'h0400);
        check("t3_rereq_count", 32'(if_hi.count), 32'd1);
        drive(1'b1, 16'h0000, 1'b1);
        push_both(4'd10, 4'd10);
        cycle();
        check("t3_pend_clear", 32'(if_hi.pend), 32'd0);
        drive(1'b1, 16'h0000, 1'b0);

        // 4: all 16 pending, en low holds pend and blocks service
        drive(1'b1, 16'hFFFF, 1'b0);
        cycle();
        check("t4_count", 32'(if_hi.count), 32'd16);
        check("t4_pend", 32'(if_hi.pend), 32'hFFFF);
        drive(1'b0, 16'hFFFF, 1'b1);
        #1;
        check("t4_en0_valid", 32'(if_hi.valid), 32'd0);
        check("t4_en0_code", 32'(if_hi.code), 32'd0);
        check("t4_en0_count", 32'(if_hi.count), 32'd16);
        cycle();
        check("t4_en0_pend", 32'(if_hi.pend), 32'hFFFF);
        check("t4_en0_dropped", 32'(if_hi.dropped), 32'd0);
        drive(1'b1, 16'h0000, 1'b0);
        #1;
        check("t4_reen_code_hi", 32'(if_hi.code), 32'd15);
        check("t4_reen_code_lo", 32'(if_lo.code), 32'd0);
        check("t4_reen_pend", 32'(if_hi.pend), 32'hFFFF);
        drive(1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) push_both(4'(15 - i), 4'(i));
        repeat (16) cycle();
        check("t4_drained_valid", 32'(if_hi.valid), 32'd0);
        check("t4_drained_count", 32'(if_lo.count), 32'd0);
        drive(1'b1, 16'h0000, 1'b0);

        // 5: async reset mid-drain
        drive(1'b1, 16'h00F0, 1'b0);
        cycle();
        drive(1'b1, 16'h0000, 1'b1);
        push_both(4'd7, 4'd4);
        cycle();
        drive(1'b1, 16'h0000, 1'b0);
        check("t5_pend_hi", 32'(if_hi.pend), 32'h0070);
        check("t5_pend_lo", 32'(if_lo.pend), 32'h00E0);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_pend_hi", 32'(if_hi.pend), 32'd0);
        check("t5_rst_pend_lo", 32'(if_lo.pend), 32'd0);
        check("t5_rst_valid", 32'(if_hi.valid), 32'd0);
        check("t5_rst_count", 32'(if_hi.count), 32'd0);
        cycle();
        reset = 1'b0;
        drive(1'b1, 16'h0002, 1'b0);
        cycle();
        check("t5_code_hi", 32'(if_hi.code), 32'd1);
        check("t5_code_lo", 32'(if_lo.code), 32'd1);
        drive(1'b1, 16'h0000, 1'b1);
        push_both(4'd1, 4'd1);
        cycle();
        drive(1'b1, 16'h0000, 1'b0);
        check("t5_valid_after", 32'(if_hi.valid), 32'd0);

        // 6: random sparse requests and acks against a reference model
        ph = 16'h0000;
        pl = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_req = 16'($urandom & $urandom & $urandom);
            r_ack = 1'($urandom_range(0, 1));
            drive(r_en, r_req, r_ack);
            cap   = r_en ? r_req : 16'h0000;
            clr_h = 16'h0000;
            clr_l = 16'h0000;
            if (r_en && ph != 16'h0000 && r_ack) begin
                c = pick(ph, 1'b1);
                q_hi.push_back(c);
                clr_h[c] = 1'b1;
            end
            if (r_en && pl != 16'h0000 && r_ack) begin
                c = pick(pl, 1'b0);
                q_lo.push_back(c);
                clr_l[c] = 1'b1;
            end
            nh = (ph & ~clr_h) | cap;
            nl = (pl & ~clr_l) | cap;
            dh = |(cap & ph & ~clr_h);
            dl = |(cap & pl & ~clr_l);
            ph = nh;
            pl = nl;
            cycle();
            check("r_pend_hi", 32'(if_hi.pend), 32'(ph));
            check("r_pend_lo", 32'(if_lo.pend), 32'(pl));
            check("r_dropped_hi", 32'(if_hi.dropped), 32'(dh));
            check("r_dropped_lo", 32'(if_lo.dropped), 32'(dl));
            check("r_count_hi", 32'(if_hi.count), 32'($countones(ph)));
            check("r_count_lo", 32'(if_lo.count), 32'($countones(pl)));
        end
        drive(1'b0, 16'h0000, 1'b0);
        cycle();

        check("q_hi_empty", 32'(q_hi.size()), 32'd0);
        check("q_lo_empty", 32'(q_lo.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
